f_prefetch_unit: RTL and testbench

F_PREFETCH_UNIT -- requirements
Module: f_prefetch_unit

---
 rtl/f_prefetch_unit.sv | 174 +++++++++++++++++
 tb/tb_f_prefetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f_prefetch_unit.sv
// Instruction prefetch unit: issues in-order fetch requests, pairs responses with
// their addresses and buffers {pc, instr, exc} entries for the decode stage.
module f_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  localparam int QW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SUMW = CW + 1;
  localparam int OW   = $clog2(MAX_OS + 1);
  localparam int SW   = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;

  localparam logic [QW-1:0]   Q_ONE   = QW'(1'b1);
  localparam logic [CW-1:0]   C_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]   C_FULL  = CW'(DEPTH);
  localparam logic [OW-1:0]   O_ONE   = OW'(1'b1);
  localparam logic [OW-1:0]   O_MAX   = OW'(MAX_OS);
  localparam logic [SUMW-1:0] S_DEPTH = SUMW'(DEPTH);
  localparam logic [SW-1:0]   SH_LAST = SW'(MAX_OS - 1);

  function automatic logic [SW-1:0] sh_inc(input logic [SW-1:0] p);
    logic [SW-1:0] n;
    if (p == SH_LAST) begin
      n = {SW{1'b0}};
    end else begin
      n = p + SW'(1'b1);
    end
    return n;
  endfunction

  logic [31:0]   fpc_r;
  logic          halt_r;
  logic [OW-1:0] os_r;
  logic [OW-1:0] drop_r;
  logic [CW-1:0] count_r;
  logic [QW-1:0] wr_ptr_r;
  logic [QW-1:0] rd_ptr_r;
  logic [SW-1:0] sh_wr_r;
  logic [SW-1:0] sh_rd_r;

  logic [31:0] q_pc_r    [DEPTH];
  logic [31:0] q_instr_r [DEPTH];
  logic        q_exc_r   [DEPTH];
  logic [31:0] sh_pc_r   [MAX_OS];

  logic          req_valid_s;
  logic          req_hs_s;
  logic          resp_keep_s;
  logic          misalign_push_s;
  logic          push_s;
  logic          pop_s;
  logic          out_valid_s;
  logic [SUMW-1:0] occ_s;
  logic [OW-1:0] os_next_s;
  logic [CW-1:0] count_next_s;
  logic [31:0]   push_pc_s;
  logic [31:0]   push_instr_s;
  logic          push_exc_s;

  // Slots already promised to in-flight requests count against queue space.
  assign occ_s       = {1'b0, count_r} + SUMW'(os_r);
  assign req_valid_s = !reset && !halt_r && !redirect && (fpc_r[1:0] == 2'b00) &&
                       (os_r < O_MAX) && (occ_s < S_DEPTH);
  assign req_hs_s    = req_valid_s && req_ready;
  assign resp_keep_s = resp_valid && (drop_r == {OW{1'b0}});
  assign misalign_push_s = !halt_r && !redirect && (fpc_r[1:0] != 2'b00) &&
                           (os_r == {OW{1'b0}}) && (count_r != C_FULL);
  assign push_s      = resp_keep_s || misalign_push_s;
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid_s && out_ready;
  assign os_next_s   = os_r + (req_hs_s ? O_ONE : {OW{1'b0}})
                            - (resp_valid ? O_ONE : {OW{1'b0}});

  // Occupancy update for the non-redirect case.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + C_ONE;
      2'b01:   count_next_s = count_r - C_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Select entry contents: a memory response or a misaligned-address fault.
  always_comb begin
    push_pc_s    = 32'h0000_0000;
    push_instr_s = 32'h0000_0000;
    push_exc_s   = 1'b0;
    if (resp_keep_s) begin
      push_pc_s    = sh_pc_r[sh_rd_r];
      push_instr_s = resp_data;
      push_exc_s   = 1'b0;
    end else begin
      push_pc_s    = fpc_r;
      push_instr_s = 32'h0000_0000;
      push_exc_s   = 1'b1;
    end
  end

  // Control state; redirect leaves in-flight responses to be dropped as they return.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_r    <= RESET_PC;
      halt_r   <= 1'b0;
      os_r     <= {OW{1'b0}};
      drop_r   <= {OW{1'b0}};
      count_r  <= {CW{1'b0}};
      wr_ptr_r <= {QW{1'b0}};
      rd_ptr_r <= {QW{1'b0}};
      sh_wr_r  <= {SW{1'b0}};
      sh_rd_r  <= {SW{1'b0}};
    end else begin
      os_r <= os_next_s;
      if (req_hs_s) sh_wr_r <= sh_inc(sh_wr_r);
      if (resp_valid) sh_rd_r <= sh_inc(sh_rd_r);
      if (redirect) begin
        fpc_r    <= redirect_pc;
        halt_r   <= 1'b0;
        drop_r   <= os_next_s;
        count_r  <= {CW{1'b0}};
        wr_ptr_r <= {QW{1'b0}};
        rd_ptr_r <= {QW{1'b0}};
      end else begin
        if (req_hs_s) fpc_r <= fpc_r + 32'd4;
        if (misalign_push_s) halt_r <= 1'b1;
        if (resp_valid && (drop_r != {OW{1'b0}})) drop_r <= drop_r - O_ONE;
        if (push_s) wr_ptr_r <= wr_ptr_r + Q_ONE;
        if (pop_s) rd_ptr_r <= rd_ptr_r + Q_ONE;
        count_r <= count_next_s;
      end
    end
  end

  // Fetch queue storage.
  always_ff @(posedge clk) begin
    if (push_s && !redirect && !reset) begin
      q_pc_r[wr_ptr_r]    <= push_pc_s;
      q_instr_r[wr_ptr_r] <= push_instr_s;
      q_exc_r[wr_ptr_r]   <= push_exc_s;
    end
  end

  // Shadow of issued addresses, consumed in order by responses.
  always_ff @(posedge clk) begin
    if (req_hs_s) begin
      sh_pc_r[sh_wr_r] <= fpc_r;
    end
  end

  assign req_valid = req_valid_s;
  assign req_addr  = fpc_r;
  assign out_valid = out_valid_s;
  assign out_pc    = out_valid_s ? q_pc_r[rd_ptr_r]    : 32'h0000_0000;
  assign out_instr = out_valid_s ? q_instr_r[rd_ptr_r] : 32'h0000_0000;
  assign out_exc   = out_valid_s ? q_exc_r[rd_ptr_r]   : 1'b0;

endmodule

// File: tb/tb_f_prefetch_unit.sv
// Directed bench for f_prefetch_unit with a 1-cycle memory returning addr^32'hFFFF.
module tb_f_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  logic        mem_hold;
  logic [31:0] mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic [31:0] got_exc[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          hs_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          k;
  int          gsz;

  f_prefetch_unit dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  // Memory bookkeeping and decode-side capture at each active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      mq.delete();
      got_pc.delete();
      got_ins.delete();
      got_exc.delete();
      got_cyc.delete();
      hs_cnt <= 0;
    end else begin
      if (resp_valid && mq.size() > 0) void'(mq.pop_front());
      if (req_valid && req_ready) begin
        mq.push_back(req_addr);
        hs_cnt <= hs_cnt + 1;
      end
      if (out_valid && out_ready && !redirect) begin
        got_pc.push_back(out_pc);
        got_ins.push_back(out_instr);
        got_exc.push_back({31'd0, out_exc});
        got_cyc.push_back(cyc);
      end
    end
  end

  // Memory response driver, 2 time units after the edge.
  initial begin
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_hold && mq.size() > 0) begin
        resp_valid = 1'b1;
        resp_data  = mq[0] ^ 32'h0000_FFFF;
      end else begin
        resp_valid = 1'b0;
        resp_data  = 32'h0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gpc(int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] gins(int i);
    return (i < got_ins.size()) ? got_ins[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] gexc(int i);
    return (i < got_exc.size()) ? got_exc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int gcyc(int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b1; out_ready = 1'b1; mem_hold = 1'b0;

    // Reset state, first request, address stability under backpressure, streaming
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check_val("rst_out_pc", out_pc, 32'h0);
    check_val("rst_out_instr", out_instr, 32'h0);
    check_val("rst_out_exc", {31'd0, out_exc}, 32'd0);
    reset = 1'b0; req_ready = 1'b0;
    #1;
    check_val("first_req_valid", {31'd0, req_valid}, 32'd1);
    check_val("first_req_addr", req_addr, 32'h0000_3000);
    repeat (2) @(negedge clk);
    check_val("stall_req_valid", {31'd0, req_valid}, 32'd1);
    check_val("stall_req_addr", req_addr, 32'h0000_3000);
    check_val("stall_no_hs", hs_cnt, 32'd0);
    req_ready = 1'b1;
    k = cyc;
    repeat (8) @(negedge clk);
    check_val("seq_pc0", gpc(0), 32'h0000_3000);
    check_val("seq_in0", gins(0), 32'h0000_CFFF);
    check_val("seq_pc1", gpc(1), 32'h0000_3004);
    check_val("seq_in1", gins(1), 32'h0000_CFFB);
    check_val("seq_pc2", gpc(2), 32'h0000_3008);
    check_val("seq_in2", gins(2), 32'h0000_CFF7);
    check_val("seq_latency", gcyc(0) - k, 32'd2);
    check_val("seq_gap01", gcyc(1) - gcyc(0), 32'd1);
    check_val("seq_gap12", gcyc(2) - gcyc(1), 32'd1);

    // Decode stalled: queue fills to DEPTH then drains and fetch resumes
    out_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check_val("full_hs_cnt", hs_cnt, 32'd4);
    check_val("full_req_valid", {31'd0, req_valid}, 32'd0);
    check_val("full_out_valid", {31'd0, out_valid}, 32'd1);
    check_val("full_head_pc", out_pc, 32'h0000_3000);
    check_val("full_no_pop", got_pc.size(), 32'd0);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_val("drain_pc0", gpc(0), 32'h0000_3000);
    check_val("drain_pc1", gpc(1), 32'h0000_3004);
    check_val("drain_pc2", gpc(2), 32'h0000_3008);
    check_val("drain_pc3", gpc(3), 32'h0000_300C);
    check_val("drain_pc4", gpc(4), 32'h0000_3010);
    check_val("drain_in4", gins(4), 32'h0000_CFEF);
    check_val("drain_gaps", gcyc(4) - gcyc(0), 32'd4);

    // Two in flight, redirect while the first response returns
    mem_hold = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    check_val("os2_hs_cnt", hs_cnt, 32'd2);
    check_val("os2_req_valid", {31'd0, req_valid}, 32'd0);
    mem_hold = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_4000;
    @(negedge clk);
    redirect = 1'b0;
    repeat (8) @(negedge clk);
    check_val("redir_pc0", gpc(0), 32'h0000_4000);
    check_val("redir_in0", gins(0), 32'h0000_BFFF);

    // Redirect during streaming, wrap through 32'hFFFF_FFFC
    do_reset();
    repeat (4) @(negedge clk);
    check_val("wrap_pre_valid", {31'd0, out_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    check_val("wrap_flush_valid", {31'd0, out_valid}, 32'd0);
    gsz = got_pc.size();
    repeat (8) @(negedge clk);
    check_val("wrap_pc0", gpc(gsz), 32'hFFFF_FFF8);
    check_val("wrap_in0", gins(gsz), 32'hFFFF_0007);
    check_val("wrap_pc1", gpc(gsz + 1), 32'hFFFF_FFFC);
    check_val("wrap_pc2", gpc(gsz + 2), 32'h0000_0000);
    check_val("wrap_in2", gins(gsz + 2), 32'h0000_FFFF);

    // Misaligned redirect: one fault entry, then halt until the next redirect
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    @(negedge clk);
    redirect = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mis_hs_cnt", hs_cnt, 32'd0);
    check_val("mis_req_valid", {31'd0, req_valid}, 32'd0);
    check_val("mis_entries", got_pc.size(), 32'd1);
    check_val("mis_pc", gpc(0), 32'h0000_4002);
    check_val("mis_instr", gins(0), 32'h0000_0000);
    check_val("mis_exc", gexc(0), 32'd1);
    check_val("mis_empty", {31'd0, out_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    @(negedge clk);
    redirect = 1'b0;
    repeat (6) @(negedge clk);
    check_val("resume_pc", gpc(1), 32'h0000_5000);
    check_val("resume_exc", gexc(1), 32'd0);
    check_val("resume_in", gins(1), 32'h0000_AFFF);

    // Reset mid-transaction with queued entries and requests in flight
    out_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    mem_hold = 1'b1;
    @(negedge clk);
    check_val("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_req_valid", {31'd0, req_valid}, 32'd0);
    check_val("mid_out_pc", out_pc, 32'h0);
    check_val("mid_out_instr", out_instr, 32'h0);
    check_val("mid_out_exc", {31'd0, out_exc}, 32'd0);
    reset = 1'b0; mem_hold = 1'b0; out_ready = 1'b1;
    #1;
    check_val("mid_restart_valid", {31'd0, req_valid}, 32'd1);
    check_val("mid_restart_addr", req_addr, 32'h0000_3000);
    repeat (6) @(negedge clk);
    check_val("mid_pc0", gpc(0), 32'h0000_3000);
    check_val("mid_in0", gins(0), 32'h0000_CFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
